// File: rtl/inst_rom_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | inst_rom_responder_pkg                                                     |
// | Shared state encodings and fetch-interface constants.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package inst_rom_responder_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_LOAD  = 2'd1,
    STATE_SERVE = 2'd2
  } state_t;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic        RESET_ENABLE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/inst_rom_responder_load_word_packer.sv
// +----------------------------------------------------------------------------+
// | load_word_packer                                                           |
// | Packs program bytes MSB-first into 32-bit words, zero-padding on last.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_word_packer
  import inst_rom_responder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_byte_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_valid,
  output logic [31:0] o_word_data
);

  logic [1:0]  r_count;
  logic [31:0] r_pack;
  logic [31:0] w_placed;
  logic        w_word_valid;
  logic [31:0] w_word_data;

  // Bytes not yet received stay zero in r_pack, which gives the padding for free.
  always_comb begin
    w_placed     = {i_byte, 24'h00_0000} >> {r_count, 3'b000};
    w_word_data  = r_pack | w_placed;
    w_word_valid = i_byte_accept && ((r_count == 2'd3) || i_last);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) begin
      r_count <= 2'd0;
      r_pack  <= 32'h0;
    end else if (i_byte_accept) begin
      if (w_word_valid) begin
        r_count <= 2'd0;
        r_pack  <= 32'h0;
      end else begin
        r_count <= r_count + 2'd1;
        r_pack  <= w_word_data;
      end
    end
  end

  assign o_word_valid = w_word_valid;
  assign o_word_data  = w_word_data;

endmodule

`default_nettype wire

// File: rtl/inst_rom_responder.sv
// +----------------------------------------------------------------------------+
// | inst_rom_responder                                                         |
// | Byte-loaded instruction RAM answering fetches with one-cycle latency.      |
// | Optional macro INST_ROM_CHECKSUM_EN enables the running write checksum.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_chip_enable,
  input  logic [31:0] i_address,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_fetch_error,
  input  logic        i_load_valid,
  input  logic [7:0]  i_load_byte,
  input  logic        i_load_last,
  output logic        o_load_ready,
  output logic        o_load_overflow,
  output logic [31:0] o_checksum
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_words = 1'b1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_ptr_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  r_overflow;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_instruction;
  logic                  r_instruction_valid;
  logic                  r_fetch_error;

  logic                  w_load_ready;
  logic                  w_accept;
  logic                  w_word_valid;
  logic [31:0]           w_word_data;
  logic                  w_write;
  logic                  w_addr_err;
  logic [ADDR_WIDTH-1:0] w_rd_idx;

  assign w_load_ready = (r_state != STATE_SERVE);
  assign w_accept     = i_load_valid && w_load_ready;

  load_word_packer u_packer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_byte_accept (w_accept),
    .i_byte        (i_load_byte),
    .i_last        (i_load_last),
    .o_word_valid  (w_word_valid),
    .o_word_data   (w_word_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_IDLE:  if (w_accept) w_state_next = i_load_last ? STATE_SERVE : STATE_LOAD;
      STATE_LOAD:  if (w_accept && i_load_last) w_state_next = STATE_SERVE;
      STATE_SERVE: w_state_next = STATE_SERVE;
      default:     w_state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) r_state <= STATE_IDLE;
    else                         r_state <= w_state_next;
  end

  // The pointer saturates at depth; a word arriving there is dropped and flagged.
  assign w_write = w_word_valid && (r_ptr != c_depth_words);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) begin
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else if (w_write) begin
      r_ptr      <= r_ptr + c_ptr_one;
    end else if (w_word_valid) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[r_ptr[ADDR_WIDTH-1:0]] <= w_word_data;
  end

  assign w_rd_idx   = i_address[ADDR_WIDTH+1:2];
  assign w_addr_err = (i_address[1:0] != 2'b00) || ((i_address >> (ADDR_WIDTH + 2)) != 32'h0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) begin
      r_instruction       <= NOP;
      r_instruction_valid <= 1'b0;
      r_fetch_error       <= 1'b0;
    end else begin
      r_instruction       <= NOP;
      r_instruction_valid <= 1'b0;
      r_fetch_error       <= 1'b0;
      if ((i_chip_enable == CHIP_ENABLE) && (r_state == STATE_SERVE)) begin
        if (w_addr_err) begin
          r_fetch_error <= 1'b1;
        end else begin
          r_instruction       <= r_mem[w_rd_idx];
          r_instruction_valid <= 1'b1;
        end
      end
    end
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) r_checksum <= 32'h0;
    else if (w_write)            r_checksum <= r_checksum + w_word_data;
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 32'h0;
`endif

  assign o_instruction       = r_instruction;
  assign o_instruction_valid = r_instruction_valid;
  assign o_fetch_error       = r_fetch_error;
  assign o_load_ready        = w_load_ready;
  assign o_load_overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_responder.sv
// +----------------------------------------------------------------------------+
// | tb_inst_rom_responder                                                      |
// | Self-checking bench: vector table, directed sequences, random vs model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_inst_rom_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce = 1'b0, lv = 1'b0, ll = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [7:0]  lb = 8'h0;
  logic [31:0] inst, csum;
  logic        iv, ferr, lrdy, lovf;

  logic        b_ce = 1'b0, b_lv = 1'b0, b_ll = 1'b0;
  logic [31:0] b_addr = 32'h0;
  logic [7:0]  b_lb = 8'h0;
  logic [31:0] b_inst, b_csum;
  logic        b_iv, b_ferr, b_lrdy, b_lovf;

  inst_rom_responder #(.ADDR_WIDTH(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_chip_enable(ce), .i_address(addr),
    .o_instruction(inst), .o_instruction_valid(iv), .o_fetch_error(ferr),
    .i_load_valid(lv), .i_load_byte(lb), .i_load_last(ll),
    .o_load_ready(lrdy), .o_load_overflow(lovf), .o_checksum(csum)
  );

  inst_rom_responder #(.ADDR_WIDTH(2)) dut_small (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_chip_enable(b_ce), .i_address(b_addr),
    .o_instruction(b_inst), .o_instruction_valid(b_iv), .o_fetch_error(b_ferr),
    .i_load_valid(b_lv), .i_load_byte(b_lb), .i_load_last(b_ll),
    .o_load_ready(b_lrdy), .o_load_overflow(b_lovf), .o_checksum(b_csum)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the 1024-word instance: RAM image, write sum, serve flag.
  logic [31:0] m_mem [int];
  logic [31:0] m_sum;
  bit          m_serve;

  typedef struct {
    logic [31:0] a;
    logic        c;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b[$], input int w);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < 4; k++)
      if (4 * w + k < b.size()) v = v | (32'(b[4 * w + k]) << (24 - 8 * k));
    return v;
  endfunction

  function automatic logic [31:0] exp_csum(input logic [31:0] s);
`ifdef INST_ROM_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; ce = 1'b0; lv = 1'b0; ll = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_sum = 32'h0;
    m_serve = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] b[$], input bit last, input bit gaps);
    int nw;
    for (int i = 0; i < b.size(); i++) begin
      check("load.ready", {31'h0, lrdy}, 32'h1);
      lv = 1'b1; lb = b[i]; ll = last && (i == b.size() - 1);
      @(posedge clk); #1;
      lv = 1'b0; ll = 1'b0;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk); #1;
      end
    end
    nw = last ? (b.size() + 3) / 4 : b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      m_mem[w] = pack_word(b, w);
      m_sum    = m_sum + m_mem[w];
    end
    if (last) m_serve = 1'b1;
  endtask

  task automatic fetch_a(input logic [31:0] a, input string nm);
    logic [31:0] ei;
    logic        ev, ee;
    ce = 1'b1; addr = a;
    @(posedge clk); #1;
    ce = 1'b0;
    ei = 32'h0; ev = 1'b0; ee = 1'b0;
    if (m_serve) begin
      if ((a % 4 != 0) || (a >= 32'd4096)) ee = 1'b1;
      else begin
        ev = 1'b1;
        if (m_mem.exists(int'(a / 4))) ei = m_mem[int'(a / 4)];
      end
    end
    check({nm, ".inst"}, inst, ei);
    check({nm, ".valid"}, {31'h0, iv}, {31'h0, ev});
    check({nm, ".ferr"}, {31'h0, ferr}, {31'h0, ee});
  endtask

  initial begin
    vec_t        tbl[$];
    logic [7:0]  prog[$];
    logic [31:0] bw[4];
    logic [31:0] bsum;
    int          n;

    // Reset state, chip_enable low, then a fetch while still in IDLE.
    do_reset();
    @(posedge clk); #1;
    check("rst.inst", inst, 32'h0);
    check("rst.valid", {31'h0, iv}, 32'h0);
    check("rst.ferr", {31'h0, ferr}, 32'h0);
    check("rst.ready", {31'h0, lrdy}, 32'h1);
    check("rst.ovf", {31'h0, lovf}, 32'h0);
    check("rst.csum", csum, 32'h0);
    fetch_a(32'h0, "idle_fetch");

    // Two-word program, then table of back-to-back fetches.
    prog = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h3C, 8'h03, 8'h12, 8'h34};
    load_a(prog, 1'b1, 1'b0);
    check("serve.ready", {31'h0, lrdy}, 32'h0);
    tbl = '{
      '{32'h0000_0000, 1'b1, 32'h2402_0005, 1'b1, 1'b0},
      '{32'h0000_0004, 1'b1, 32'h3C03_1234, 1'b1, 1'b0},
      '{32'h0000_0002, 1'b1, 32'h0,         1'b0, 1'b1},
      '{32'h0000_1000, 1'b1, 32'h0,         1'b0, 1'b1},
      '{32'h0000_0004, 1'b0, 32'h0,         1'b0, 1'b0},
      '{32'h0000_0003, 1'b1, 32'h0,         1'b0, 1'b1},
      '{32'h8000_0000, 1'b1, 32'h0,         1'b0, 1'b1},
      '{32'h0000_0000, 1'b1, 32'h2402_0005, 1'b1, 1'b0}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      ce = tbl[i].c; addr = tbl[i].a;
      @(posedge clk); #1;
      check($sformatf("tbl%0d.inst", i), inst, tbl[i].e_inst);
      check($sformatf("tbl%0d.valid", i), {31'h0, iv}, {31'h0, tbl[i].e_valid});
      check($sformatf("tbl%0d.ferr", i), {31'h0, ferr}, {31'h0, tbl[i].e_err});
    end
    ce = 1'b0;
    check("two_word.csum", csum, exp_csum(32'h6005_1239));

    // Bytes offered in SERVE must be ignored.
    for (int i = 0; i < 3; i++) begin
      lv = 1'b1; lb = 8'hEE; ll = (i == 2);
      @(posedge clk); #1;
    end
    lv = 1'b0; ll = 1'b0;
    fetch_a(32'h0, "serve_ignore0");
    fetch_a(32'h4, "serve_ignore4");
    check("serve_ignore.csum", csum, exp_csum(m_sum));

    // Five-byte program: last word zero-padded.
    do_reset();
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_a(prog, 1'b1, 1'b0);
    ce = 1'b1; addr = 32'h4;
    @(posedge clk); #1;
    ce = 1'b0;
    check("pad.inst", inst, 32'h5500_0000);
    check("pad.valid", {31'h0, iv}, 32'h1);
    check("pad.csum", csum, exp_csum(32'h6622_3344));
    fetch_a(32'h0, "pad0");

    // Reset in mid-load: completed words survive, partial word is discarded.
    do_reset();
    prog = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    load_a(prog, 1'b1, 1'b0);
    do_reset();
    prog = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
    load_a(prog, 1'b0, 1'b0);
    check("midload.ready", {31'h0, lrdy}, 32'h1);
    fetch_a(32'h0, "midload_fetch");
    do_reset();
    check("midreset.csum", csum, 32'h0);
    prog = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load_a(prog, 1'b1, 1'b0);
    check("reload.ready", {31'h0, lrdy}, 32'h0);
    fetch_a(32'h0, "reload0");
    fetch_a(32'h4, "reload4");
    check("reload.old4", m_mem[1], 32'hA5A6_A7A8);
    check("reload.csum", csum, exp_csum(32'hC1C2_C3C4));

    // Randomized programs and fetches against the model.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      n = $urandom_range(1, 40);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      load_a(prog, 1'b1, 1'b1);
      for (int f = 0; f < 20; f++) begin
        int          idx;
        logic [31:0] a;
        idx = $urandom_range(0, (n + 3) / 4 - 1);
        case ($urandom_range(0, 3))
          0:       a = 32'(idx * 4) + 32'($urandom_range(1, 3));
          1:       a = 32'h1000 + (32'($urandom) & 32'h0FFF_FFFC);
          default: a = 32'(idx * 4);
        endcase
        fetch_a(a, $sformatf("rnd%0d_%0d", it, f));
      end
      check($sformatf("rnd%0d.csum", it), csum, exp_csum(m_sum));
      check($sformatf("rnd%0d.ovf", it), {31'h0, lovf}, 32'h0);
    end

    // Four-word instance: five full words overflow, first four retained.
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    check("small.rst_ovf", {31'h0, b_lovf}, 32'h0);
    prog.delete();
    for (int k = 0; k < 20; k++) prog.push_back(8'(16 * (k / 4 + 1) + k % 4));
    bsum = 32'h0;
    for (int w = 0; w < 4; w++) begin
      bw[w] = pack_word(prog, w);
      bsum  = bsum + bw[w];
    end
    for (int k = 0; k < 20; k++) begin
      b_lv = 1'b1; b_lb = prog[k]; b_ll = (k == 19);
      @(posedge clk); #1;
    end
    b_lv = 1'b0; b_ll = 1'b0;
    check("small.ovf", {31'h0, b_lovf}, 32'h1);
    check("small.ready", {31'h0, b_lrdy}, 32'h0);
    check("small.csum", b_csum, exp_csum(bsum));
    for (int k = 0; k < 4; k++) begin
      b_ce = 1'b1; b_addr = 32'(k * 4);
      @(posedge clk); #1;
      b_ce = 1'b0;
      check($sformatf("small%0d.inst", k), b_inst, bw[k]);
      check($sformatf("small%0d.valid", k), {31'h0, b_iv}, 32'h1);
    end
    b_ce = 1'b1; b_addr = 32'h10;
    @(posedge clk); #1;
    b_ce = 1'b0;
    check("small.range_err", {31'h0, b_ferr}, 32'h1);
    check("small.range_inst", b_inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_rom_responder.md
Name: inst_rom_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface: the fetch stage drives chip_enable and a byte address (PC); this block returns the addressed instruction word one cycle later.
- Holds a word-addressed instruction RAM, filled before execution through a byte-serial program-load port with a valid/ready handshake.
- A three-state controller sequences load, then serve.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- chip_enable  in  1  fetch request qualifier from the fetch stage
- address  in  32  byte address (PC) from the fetch stage
- instruction  out  32  fetched word; 32'h0 (NOP) when not valid
- instruction_valid  out  1  instruction holds a real fetched word
- fetch_error  out  1  registered; misaligned or out-of-range fetch this cycle
- load_valid  in  1  load byte present
- load_byte  in  8  program byte, big-endian within a word
- load_last  in  1  marks the final byte of the program
- load_ready  out  1  block accepts a load byte
- load_overflow  out  1  sticky; program exceeded depth
- checksum  out  32  see Optional Feature

Behaviour:
- Reset values (asynchronous, reset low):
  - state = IDLE; instruction = 0; instruction_valid = 0; fetch_error = 0; load_ready = 1; load_overflow = 0.
  - Byte counter = 0; word pointer = 0; pack register = 0.
  - RAM contents are NOT cleared.
- States:
  - IDLE: waits for the first load byte.
  - LOAD: assembling words.
  - SERVE: answers fetches.
- Transitions:
  - IDLE -> LOAD on the first accepted byte.
  - LOAD -> SERVE on the accepted byte with load_last = 1.
  - SERVE is left only by reset.
- Load handshake:
  - A byte is accepted when load_valid && load_ready.
  - load_ready = 1 in IDLE/LOAD and 0 in SERVE.
  - Bytes pack MSB-first: byte 0 goes to [31:24] and byte 3 to [7:0].
  - On the 4th byte, the word is written to RAM[pointer], the pointer increments, and the byte counter returns to 0.
- load_last on a partial word:
  - The remaining low bytes are zero-padded and the word is written in the same cycle.
  - Example: 2 bytes AA, BB -> 32'hAABB0000.
- Overflow:
  - A write attempted with pointer == depth is dropped and load_overflow is set (sticky until reset).
  - The pointer saturates at depth and does not wrap.
- Serve, with chip_enable = 1 sampled at a rising edge:
  - Word index = address[ADDR_WIDTH+1:2].
  - Result appears after that edge (1-cycle latency) with instruction_valid = 1.
- Fetch errors:
  - address[1:0] != 0, or any of address[31:ADDR_WIDTH+2] nonzero, gives instruction = 0, instruction_valid = 0 and fetch_error = 1 for that response cycle.
- chip_enable = 0 at an edge: the next cycle has instruction = 0, valid = 0, fetch_error = 0.
- chip_enable = 1 while in IDLE/LOAD: responds with NOP, valid = 0, fetch_error = 0; there is no stall output.
- Bytes presented in SERVE are ignored because load_ready = 0.
- Reset mid-load:
  - Returns to IDLE with the pointer and counter at 0.
  - A partially packed word is discarded; previously written words remain in RAM.

Optional Feature:
- INST_ROM_CHECKSUM_EN defined:
  - checksum = 32-bit wrapping sum of every word actually written to RAM (padded words included, dropped overflow words excluded).
  - Updated in the write cycle; reset to 0.
- Macro undefined: checksum tied to 32'h0 and no adder is synthesised.

Decomposition:
- Shared package (cpu definitions file) holds:
  - State encodings STATE_IDLE, STATE_LOAD, STATE_SERVE.
  - NOP constant 32'h0.
  - CHIP_ENABLE/CHIP_DISABLE and RESET_ENABLE (active-low) constants.
- One sub-module: load_word_packer.
  - Contains the byte counter, shift/pack register and zero-pad-on-last logic.
  - Emits word_valid and word_data.
- The top level holds the FSM, pointer, RAM, read path and checksum.

Test Plan:
- Reset release, chip_enable = 0 -> instruction = 0, valid = 0, load_ready = 1, state IDLE.
- Load bytes 24 02 00 05 3C 03 12 34 with load_last on the final byte, then chip_enable = 1 and address 0 then 4 -> 32'h24020005 then 32'h3C031234, each with valid = 1 one cycle after the request edge; load_ready = 0.
- Load 5 bytes 11 22 33 44 55 with last -> address 4 returns 32'h55000000; with the macro defined, checksum = 32'h66223344.
- In SERVE, address 32'h2 -> fetch_error = 1 and instruction = 0; address 32'h1000 with ADDR_WIDTH = 10 -> fetch_error = 1.
- ADDR_WIDTH = 2: load 5 full words -> load_overflow = 1, and addresses 0..12 hold the first 4 words.
- Assert reset after 6 bytes of a load, release, reload 4 bytes -> the new word is at address 0, the old word at address 4 is retained, and state ends in SERVE.
